comp_flag_bank: RTL

//  Parametrised successor of the single CMP flag register. Holds NUM_BANKS

---
 rtl/comp_flag_bank.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/comp_flag_bank.sv
// ----------------------------------------------------------------------------
// comp_flag_bank
//   Bank of comparison-flag registers, one per sequencer thread. Each bank is
//   presented as {Always=1, Never=0, flags[FLAG_W-1:0]}. CMP issue and CMP
//   result are decoupled; a per-bank outstanding counter holds off branch
//   condition queries until every in-flight CMP on that bank has retired.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   i_issue_valid  ALU op issue strobe
//   i_issue_bank   bank of the issuing op
//   ALU_op         opcode; only CMP_OP is counted
//   o_issue_ready  bank of i_issue_bank can take another CMP
//   i_res_valid    CMP result strobe
//   i_res_bank     bank written by the result
//   i_res_acc      1: OR-accumulate into flags, 0: overwrite
//   i_comp_flag    ALU comparison flags
//   i_clr          per-bank flag clear (Always/Never untouched)
//   i_q_valid      condition query request
//   i_q_bank       bank queried
//   i_q_sel        condition bit index into the full bank word
//   o_q_ready      queried bank has no CMP in flight
//   o_q_valid      query response strobe (one cycle after acceptance)
//   o_q_cond       selected condition bit
//   o_comp_reg     all banks, bank b at [b*(FLAG_W+2) +: FLAG_W+2]
//   o_err          sticky protocol error, cleared only by reset
// ----------------------------------------------------------------------------

`ifndef CMP
`define CMP 4'h3
`endif

module comp_flag_bank #(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned FLAG_W    = 10,
    parameter int unsigned MAX_OUT   = 3,
    parameter logic [3:0]  CMP_OP    = `CMP,
    localparam int unsigned BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int unsigned SW = $clog2(FLAG_W + 2),
    localparam int unsigned CW = $clog2(MAX_OUT + 1),
    localparam int unsigned RW = FLAG_W + 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_issue_valid,
    input  logic [BW-1:0]           i_issue_bank,
    input  logic [3:0]              ALU_op,
    output logic                    o_issue_ready,
    input  logic                    i_res_valid,
    input  logic [BW-1:0]           i_res_bank,
    input  logic                    i_res_acc,
    input  logic [FLAG_W-1:0]       i_comp_flag,
    input  logic [NUM_BANKS-1:0]    i_clr,
    input  logic                    i_q_valid,
    input  logic [BW-1:0]           i_q_bank,
    input  logic [SW-1:0]           i_q_sel,
    output logic                    o_q_ready,
    output logic                    o_q_valid,
    output logic                    o_q_cond,
    output logic [NUM_BANKS*RW-1:0] o_comp_reg,
    output logic                    o_err
);

    // Only the writable flag bits are stored; Always/Never are constants.
    logic [FLAG_W-1:0] r_flags [NUM_BANKS];
    logic [CW-1:0]     r_cnt   [NUM_BANKS];
    logic              r_q_valid;
    logic              r_q_cond;
    logic              r_err;

    logic [FLAG_W-1:0] w_flags_d [NUM_BANKS];
    logic [CW-1:0]     w_cnt_d   [NUM_BANKS];

    logic              w_issue_bank_ok;
    logic              w_res_bank_ok;
    logic              w_q_bank_ok;
    logic              w_is_cmp;
    logic              w_issue_rdy;
    logic              w_issue_acc;
    logic              w_issue_err;
    logic [CW-1:0]     w_res_cnt;
    logic              w_res_ok;
    logic              w_res_err;
    logic              w_q_rdy;
    logic              w_q_acc;
    logic              w_q_err;
    logic [RW-1:0]     w_q_word;
    logic              w_q_bit;

    // Bank range checks; indices are only used once qualified by these.
    assign w_issue_bank_ok = 32'(i_issue_bank) < NUM_BANKS;
    assign w_res_bank_ok   = 32'(i_res_bank) < NUM_BANKS;
    assign w_q_bank_ok     = 32'(i_q_bank) < NUM_BANKS;

    assign w_is_cmp    = (ALU_op == CMP_OP);
    assign w_issue_rdy = w_issue_bank_ok && (r_cnt[i_issue_bank] < CW'(MAX_OUT));
    assign w_issue_acc = i_issue_valid && w_is_cmp && w_issue_rdy;
    // Covers both a full bank and an out-of-range bank.
    assign w_issue_err = i_issue_valid && w_is_cmp && !w_issue_rdy;

    assign w_res_cnt = w_res_bank_ok ? r_cnt[i_res_bank] : '0;
    assign w_res_ok  = i_res_valid && w_res_bank_ok;
    assign w_res_err = i_res_valid && (!w_res_bank_ok || (w_res_cnt == '0));

    assign w_q_rdy = w_q_bank_ok && (r_cnt[i_q_bank] == '0);
    assign w_q_acc = i_q_valid && w_q_rdy;
    assign w_q_err = i_q_valid && !w_q_bank_ok;

    assign o_issue_ready = w_issue_rdy;
    assign o_q_ready     = w_q_rdy;
    assign o_q_valid     = r_q_valid;
    assign o_q_cond      = r_q_cond;
    assign o_err         = r_err;

    // Condition select reads the pre-edge register; no result bypass.
    always_comb begin
        w_q_word = {1'b1, 1'b0, (w_q_bank_ok ? r_flags[i_q_bank] : {FLAG_W{1'b0}})};
        w_q_bit  = 1'b0;
        if (32'(i_q_sel) < RW) begin
            w_q_bit = w_q_word[i_q_sel];
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            logic w_hit_res;
            logic w_inc;
            logic w_dec;
            w_hit_res    = w_res_ok && (i_res_bank == BW'(b));
            w_inc        = w_issue_acc && (i_issue_bank == BW'(b));
            // A stray result on an idle bank leaves the count at zero.
            w_dec        = w_hit_res && (r_cnt[b] != '0);
            w_flags_d[b] = r_flags[b];
            if (i_clr[b]) begin
                w_flags_d[b] = '0;
            end
            // Result takes priority over a same-cycle clear.
            if (w_hit_res) begin
                w_flags_d[b] = i_res_acc ? (r_flags[b] | i_comp_flag) : i_comp_flag;
            end
            w_cnt_d[b] = r_cnt[b] + CW'(w_inc) - CW'(w_dec);
        end
    end

    always_comb begin
        o_comp_reg = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            o_comp_reg[b*RW +: RW] = {1'b1, 1'b0, r_flags[b]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_flags[b] <= '0;
                r_cnt[b]   <= '0;
            end
            r_q_valid <= 1'b0;
            r_q_cond  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_flags[b] <= w_flags_d[b];
                r_cnt[b]   <= w_cnt_d[b];
            end
            r_q_valid <= w_q_acc;
            r_q_cond  <= w_q_acc ? w_q_bit : 1'b0;
            r_err     <= r_err | w_issue_err | w_res_err | w_q_err;
        end
    end

endmodule
